// File: rtl/uart_pkg.sv
// Shared definitions for the uart arbiter: FSM encoding, uart status bit
// positions, register selects and the state-to-bus decode.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STATUS   = 2'd1,
        ST_RX_READ  = 2'd2,
        ST_TX_WRITE = 2'd3
    } state_e;

    localparam int TX_BUSY_BIT = 15;
    localparam int RX_FULL_BIT = 14;

    localparam logic A0_STATUS = 1'b0;
    localparam logic A0_DATA   = 1'b1;

    typedef struct packed {
        logic cs_b;
        logic rnw;
        logic a0;
    } bus_ctl_t;

    // Idle bus is deselected and parked as a status read.
    function automatic bus_ctl_t bus_decode(input state_e st);
        bus_ctl_t ctl;
        ctl = '{cs_b: 1'b1, rnw: 1'b1, a0: A0_STATUS};
        case (st)
            ST_STATUS:   ctl = '{cs_b: 1'b0, rnw: 1'b1, a0: A0_STATUS};
            ST_RX_READ:  ctl = '{cs_b: 1'b0, rnw: 1'b1, a0: A0_DATA};
            ST_TX_WRITE: ctl = '{cs_b: 1'b0, rnw: 1'b0, a0: A0_DATA};
            default:     ;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with an owner lock for multi-byte bursts and an
// optional burst length limit that forces the lock to release.
module rr_arb2 #(
    parameter int TX_BURST = 16,
    parameter int BURST_W  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eval,
    input  logic       commit,
    input  logic       commit_idx,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(TX_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    logic               last_q, last_d;
    logic               locked_q, locked_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               release_lock;
    logic               hold_lock;

    // While locked the owner is always the last granted client.
    always_comb begin
        release_lock = locked_q && (!req[last_q] || !lock[last_q] ||
                                    ((TX_BURST != 0) && (burst_q >= BURST_LIM)));
        hold_lock    = locked_q && !release_lock;
        gnt_valid    = 1'b0;
        gnt_idx      = last_q;
        if (hold_lock) begin
            gnt_valid = req[last_q];
        end else if (req[!last_q]) begin
            gnt_valid = 1'b1;
            gnt_idx   = !last_q;
        end else if (req[last_q]) begin
            gnt_valid = 1'b1;
        end
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        last_d   = last_q;
        locked_d = locked_q;
        burst_d  = burst_q;
        if (eval && release_lock) begin
            locked_d = 1'b0;
            burst_d  = '0;
        end
        if (commit) begin
            last_d = commit_idx;
            if (lock[commit_idx]) begin
                locked_d = 1'b1;
                burst_d  = locked_q ? burst_q + BURST_ONE : BURST_ONE;
            end else begin
                locked_d = 1'b0;
                burst_d  = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= 1'b1;
            locked_q <= 1'b0;
            burst_q  <= '0;
        end else begin
            last_q   <= last_d;
            locked_q <= locked_d;
            burst_q  <= burst_d;
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// Polls a memory-mapped uart, drains RX bytes to a selected client and shares
// the transmitter between two byte-stream clients.
module uart_arbiter
    import uart_pkg::*;
#(
    parameter int TX_BURST = 16,
    parameter int BURST_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clken,
    input  logic        tx_valid_0,
    input  logic [7:0]  tx_data_0,
    input  logic        tx_lock_0,
    output logic        tx_ready_0,
    input  logic        tx_valid_1,
    input  logic [7:0]  tx_data_1,
    input  logic        tx_lock_1,
    output logic        tx_ready_1,
    input  logic        rx_sel,
    output logic [7:0]  rx_data,
    output logic        rx_valid_0,
    output logic        rx_valid_1,
    output logic        uart_cs_b,
    output logic        uart_rnw,
    output logic        uart_a0,
    output logic [15:0] uart_din,
    input  logic [15:0] uart_dout
);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [1:0]  rx_valid_q, rx_valid_d;
    logic [1:0]  tx_ready_q, tx_ready_d;
    logic        gnt_valid;
    logic        gnt_idx;
    bus_ctl_t    bus_ctl;
    logic        unused_dout;

    assign unused_dout = ^uart_dout[13:8];

    rr_arb2 #(
        .TX_BURST (TX_BURST),
        .BURST_W  (BURST_W)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .eval       (clken && (state_q == ST_STATUS)),
        .commit     (clken && (state_q == ST_TX_WRITE)),
        .commit_idx (grant_q),
        .req        ({tx_valid_1, tx_valid_0}),
        .lock       ({tx_lock_1, tx_lock_0}),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // Pulses default low every clk, so they last one clk even when clken is sparse.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = '0;
        tx_ready_d = '0;
        if (clken) begin
            case (state_q)
                ST_IDLE: state_d = ST_STATUS;
                ST_STATUS: begin
                    // RX wins over TX so the single-byte receive buffer never overruns.
                    if (uart_dout[RX_FULL_BIT]) begin
                        state_d = ST_RX_READ;
                    end else if (!uart_dout[TX_BUSY_BIT] && gnt_valid) begin
                        state_d = ST_TX_WRITE;
                        grant_d = gnt_idx;
                    end
                end
                ST_RX_READ: begin
                    rx_data_d          = uart_dout[7:0];
                    rx_valid_d[rx_sel] = 1'b1;
                    state_d            = ST_STATUS;
                end
                ST_TX_WRITE: begin
                    tx_ready_d[grant_q] = 1'b1;
                    state_d             = ST_STATUS;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= '0;
            tx_ready_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign bus_ctl    = bus_decode(state_q);
    assign uart_cs_b  = bus_ctl.cs_b;
    assign uart_rnw   = bus_ctl.rnw;
    assign uart_a0    = bus_ctl.a0;
    assign uart_din   = (state_q == ST_TX_WRITE) ?
                        {8'h00, (grant_q ? tx_data_1 : tx_data_0)} : 16'h0000;

    assign rx_data    = rx_data_q;
    assign rx_valid_0 = rx_valid_q[0];
    assign rx_valid_1 = rx_valid_q[1];
    assign tx_ready_0 = tx_ready_q[0];
    assign tx_ready_1 = tx_ready_q[1];

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter with a small behavioural uart status/data model.
module tb_uart_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        tx_valid_0, tx_lock_0, tx_ready_0;
    logic [7:0]  tx_data_0;
    logic        tx_valid_1, tx_lock_1, tx_ready_1;
    logic [7:0]  tx_data_1;
    logic        rx_sel;
    logic [7:0]  rx_data;
    logic        rx_valid_0, rx_valid_1;
    logic        uart_cs_b, uart_rnw, uart_a0;
    logic [15:0] uart_din;
    logic [15:0] uart_dout;

    uart_arbiter #(.TX_BURST(3), .BURST_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .tx_valid_0 (tx_valid_0),
        .tx_data_0  (tx_data_0),
        .tx_lock_0  (tx_lock_0),
        .tx_ready_0 (tx_ready_0),
        .tx_valid_1 (tx_valid_1),
        .tx_data_1  (tx_data_1),
        .tx_lock_1  (tx_lock_1),
        .tx_ready_1 (tx_ready_1),
        .rx_sel     (rx_sel),
        .rx_data    (rx_data),
        .rx_valid_0 (rx_valid_0),
        .rx_valid_1 (rx_valid_1),
        .uart_cs_b  (uart_cs_b),
        .uart_rnw   (uart_rnw),
        .uart_a0    (uart_a0),
        .uart_din   (uart_din),
        .uart_dout  (uart_dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  c0_q[$];
    logic [7:0]  c1_q[$];
    bit          lock0_en = 1'b0;
    bit          lock1_en = 1'b0;

    int          busy_len = 0;
    int          busy_cnt = 0;
    bit          force_busy = 1'b0;
    int          rx_set = 0;
    int          rx_clr = 0;
    logic [15:0] rx_word = 16'h0000;

    logic [15:0] wr_q[$];
    int          ev_q[$];
    int          rdy0_cnt = 0, rdy1_cnt = 0, rxv0_cnt = 0, rxv1_cnt = 0;
    bit          div4 = 1'b0;
    int          phase = 0;
    logic [18:0] bus_prev = '0;
    int          bus_hold_err = 0;

    logic [7:0]  exp2 [6] = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    logic [7:0]  exp3 [6] = '{8'h41, 8'h42, 8'h43, 8'h1A, 8'h44, 8'h45};

    assign uart_dout = uart_a0 ? rx_word
                               : {((busy_cnt != 0) || force_busy), (rx_set != rx_clr), 14'h0000};

    // uart model: transmitter busy for busy_len enables after a write, rx_full until read.
    always @(posedge clk) begin
        if (!reset && clken && !uart_cs_b) begin
            if (!uart_rnw) begin
                wr_q.push_back(uart_din);
                ev_q.push_back(2);
            end else if (uart_a0) begin
                ev_q.push_back(1);
            end
        end
        if (!reset && clken && !uart_cs_b && !uart_rnw)
            busy_cnt <= busy_len;
        else if (clken && busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
        if (!reset && clken && !uart_cs_b && uart_rnw && uart_a0 && rx_set != rx_clr)
            rx_clr <= rx_clr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_clients();
        tx_valid_0 = (c0_q.size() != 0);
        tx_data_0  = (c0_q.size() != 0) ? c0_q[0] : 8'h00;
        tx_lock_0  = lock0_en && tx_valid_0;
        tx_valid_1 = (c1_q.size() != 0);
        tx_data_1  = (c1_q.size() != 0) ? c1_q[0] : 8'h00;
        tx_lock_1  = lock1_en && tx_valid_1;
    endtask

    task automatic tick();
        logic en_edge;
        logic rst_edge;
        logic [18:0] bus_now;
        @(posedge clk);
        en_edge  = clken;
        rst_edge = reset;
        #1;
        bus_now = {uart_cs_b, uart_rnw, uart_a0, uart_din};
        if (bus_now != bus_prev && !en_edge && !rst_edge) bus_hold_err++;
        bus_prev = bus_now;
        if (tx_ready_0) rdy0_cnt++;
        if (tx_ready_1) rdy1_cnt++;
        if (rx_valid_0) rxv0_cnt++;
        if (rx_valid_1) rxv1_cnt++;
        if (tx_ready_0 && c0_q.size() != 0) void'(c0_q.pop_front());
        if (tx_ready_1 && c1_q.size() != 0) void'(c1_q.pop_front());
        drive_clients();
        if (div4) begin
            phase++;
            clken = (phase % 4 == 0);
        end
    endtask

    task automatic run_clients(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (c0_q.size() == 0 && c1_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int ev_base;
        int r0;
        int r1;
        bit found;

        reset = 1'b1;
        clken = 1'b0;
        rx_sel = 1'b0;
        drive_clients();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tick();
        check("rst_cs_b",   {31'b0, uart_cs_b}, 32'd1);
        check("rst_rnw_a0", {30'b0, uart_rnw, uart_a0}, 32'h2);
        check("rst_din",    {16'b0, uart_din}, 32'h0);
        check("rst_rx_data", {24'b0, rx_data}, 32'h0);
        check("rst_pulses", {28'b0, tx_ready_0, tx_ready_1, rx_valid_0, rx_valid_1}, 32'h0);
        clken = 1'b1;

        // single byte, then a second one held off while the uart is busy
        busy_len = 6;
        base = wr_q.size();
        c0_q.push_back(8'hA5);
        c0_q.push_back(8'hB6);
        drive_clients();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rdy0_cnt >= 1) break;
        end
        check("t1_ready0", rdy0_cnt, 32'd1);
        check("t1_wr_cnt", wr_q.size() - base, 32'd1);
        check("t1_din", {16'b0, wr_q[base]}, 32'h00A5);
        repeat (3) tick();
        check("t1_busy_hold", wr_q.size() - base, 32'd1);
        check("t1_polling", {29'b0, uart_cs_b, uart_rnw, uart_a0}, 32'h2);
        run_clients(100, "t1_done");
        check("t1_din2", {16'b0, wr_q[base + 1]}, 32'h00B6);
        check("t1_rdy_counts", {rdy0_cnt[15:0], rdy1_cnt[15:0]}, 32'h0002_0000);

        // fairness after reset: client 0 first, then strict alternation
        do_reset();
        busy_len = 1;
        base = wr_q.size();
        c0_q = '{8'h11, 8'h12, 8'h13};
        c1_q = '{8'h21, 8'h22, 8'h23};
        drive_clients();
        run_clients(200, "t2_done");
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_order%0d", i), {16'b0, wr_q[base + i]}, {24'b0, exp2[i]});

        // lock with burst limit 3
        lock1_en = 1'b1;
        base = wr_q.size();
        c1_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        drive_clients();
        r1 = rdy1_cnt;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rdy1_cnt > r1) break;
        end
        check("t3_first", rdy1_cnt - r1, 32'd1);
        c0_q.push_back(8'h1A);
        drive_clients();
        run_clients(300, "t3_done");
        lock1_en = 1'b0;
        drive_clients();
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_order%0d", i), {16'b0, wr_q[base + i]}, {24'b0, exp3[i]});

        // RX priority with status 16'hC000
        repeat (4) tick();
        base = wr_q.size();
        r0 = rxv0_cnt;
        r1 = rxv1_cnt;
        force_busy = 1'b1;
        c0_q.push_back(8'h3C);
        drive_clients();
        rx_word = 16'h005A;
        rx_sel = 1'b0;
        rx_set++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rxv0_cnt > r0) break;
        end
        check("t4_rx_data", {24'b0, rx_data}, 32'h5A);
        check("t4_no_write", wr_q.size() - base, 32'd0);
        repeat (3) tick();
        check("t4_rxv0_once", rxv0_cnt - r0, 32'd1);
        check("t4_rxv1_none", rxv1_cnt - r1, 32'd0);
        check("t4_still_no_write", wr_q.size() - base, 32'd0);
        force_busy = 1'b0;
        run_clients(50, "t4_tx_done");
        check("t4_tx_byte", {16'b0, wr_q[base]}, 32'h003C);

        // rx_full and a grantable TX in the same status sample
        repeat (4) tick();
        ev_base = ev_q.size();
        c1_q.push_back(8'h5E);
        drive_clients();
        rx_word = 16'h00E7;
        rx_set++;
        run_clients(50, "t4b_done");
        check("t4b_first_rx", ev_q[ev_base], 32'd1);
        check("t4b_then_tx", ev_q[ev_base + 1], 32'd2);
        check("t4b_rx_data", {24'b0, rx_data}, 32'hE7);

        // clken every 4th clk, RX steered to client 1
        base = wr_q.size();
        r0 = rxv0_cnt;
        r1 = rxv1_cnt;
        rx_sel = 1'b1;
        rx_word = 16'h00C3;
        rx_set++;
        c1_q.push_back(8'h77);
        drive_clients();
        bus_hold_err = 0;
        phase = 0;
        clken = 1'b0;
        div4 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (c1_q.size() == 0 && rxv1_cnt > r1) break;
        end
        repeat (8) tick();
        check("t5_rx_data", {24'b0, rx_data}, 32'hC3);
        check("t5_rxv1_one_clk", rxv1_cnt - r1, 32'd1);
        check("t5_rxv0_none", rxv0_cnt - r0, 32'd0);
        check("t5_bus_hold", bus_hold_err, 32'd0);
        check("t5_tx_byte", {16'b0, wr_q[base]}, 32'h0077);
        div4 = 1'b0;
        clken = 1'b1;

        // reset in the middle of TX_WRITE
        c0_q.push_back(8'h66);
        drive_clients();
        run_clients(50, "t6_pre_done");
        repeat (4) tick();
        c1_q.push_back(8'h44);
        drive_clients();
        r1 = rdy1_cnt;
        base = wr_q.size();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!uart_cs_b && !uart_rnw) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reached_write", {31'b0, found}, 32'd1);
        reset = 1'b1;
        tick();
        check("t6_cs_b", {31'b0, uart_cs_b}, 32'd1);
        check("t6_no_ready", rdy1_cnt - r1, 32'd0);
        check("t6_no_write", wr_q.size() - base, 32'd0);
        reset = 1'b0;
        c0_q.push_back(8'h55);
        drive_clients();
        run_clients(100, "t6_done");
        check("t6_first_c0", {16'b0, wr_q[base]}, 32'h0055);
        check("t6_then_c1", {16'b0, wr_q[base + 1]}, 32'h0044);
        check("t6_ready1_once", rdy1_cnt - r1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
